// File: rtl/my_dmux_pkg.sv
// Shared constants, channel index type and select decode for the
// 16-bit 8-way registered distributor.
package my_dmux_pkg;

  localparam int N_CH      = 8;
  localparam int SEL_W     = 3;
  localparam int DEF_WIDTH = 16;

  typedef logic [SEL_W-1:0] ch_idx_t;

  // One-hot decode of a channel index, the same decode the combinational dmux uses.
  function automatic logic [N_CH-1:0] onehot8(input ch_idx_t s);
    return N_CH'(1) << s;
  endfunction

endpackage

// File: rtl/my_chan_reg.sv
// One-entry holding register for a single output channel: load wins over
// take, so a simultaneous drain and refill keeps the slot full with new data.
module my_chan_reg
  import my_dmux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             take,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = d;
      valid_d = 1'b1;
    end else if (take) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/my_dmux_16_8_way_reg.sv
// Registered 1-to-8 distributor: steers each accepted word into the holding
// register of the channel picked by sel or by the auto-increment pointer.
module my_dmux_16_8_way_reg
  import my_dmux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  auto,
  output logic [N_CH*WIDTH-1:0] out,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [SEL_W-1:0]      ptr
);

  ch_idx_t         tgt;
  ch_idx_t         ptr_q, ptr_d;
  logic            accept;
  logic [N_CH-1:0] load_vec;

  assign tgt = auto ? ptr_q : sel;

  // A slot being drained this cycle can take a new word without a bubble.
  assign in_ready = ~out_valid[tgt] | out_ready[tgt];
  assign accept   = in_valid & in_ready;
  assign load_vec = accept ? onehot8(tgt) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (accept && auto) begin
      ptr_d = ptr_q + ch_idx_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    my_chan_reg #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .load (load_vec[k]),
      .d    (in),
      .take (out_ready[k]),
      .q    (out[k*WIDTH +: WIDTH]),
      .valid(out_valid[k])
    );
  end

endmodule

// File: tb/tb_my_dmux_16_8_way_reg.sv
// Self-checking bench for my_dmux_16_8_way_reg: directed scenarios plus
// randomized traffic compared every cycle against an array-based model.
module tb_my_dmux_16_8_way_reg;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  in;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   sel;
  logic         auto;
  logic [127:0] out;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [2:0]   ptr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  my_dmux_16_8_way_reg #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .auto     (auto),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ptr      (ptr)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s got=%0h expected=%0h", name, act, exp);
  endtask

  // Behavioural model: per-channel occupancy flags, held words, pointer.
  logic [7:0]  mv = 8'h00;
  logic [15:0] md [8];
  int          mptr = 0;
  bit          started = 0;

  always @(posedge clk) begin
    int  t;
    bit  rdy;
    if (reset) begin
      mv   = 8'h00;
      mptr = 0;
      for (int k = 0; k < 8; k++) md[k] = 16'h0000;
    end else begin
      t   = auto ? mptr : int'(sel);
      rdy = !mv[t] || out_ready[t];
      for (int k = 0; k < 8; k++)
        if (mv[k] && out_ready[k]) mv[k] = 1'b0;
      if (in_valid && rdy) begin
        md[t] = in;
        mv[t] = 1'b1;
        if (auto) mptr = (mptr + 1) % 8;
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    int t;
    if (started) begin
      t = auto ? mptr : int'(sel);
      chk("out_valid", 32'(out_valid), 32'(mv));
      chk("ptr", 32'(ptr), 32'(mptr));
      chk("in_ready", 32'(in_ready), 32'(!mv[t] || out_ready[t]));
      for (int k = 0; k < 8; k++)
        chk($sformatf("data_ch%0d", k), 32'(out[k*16 +: 16]), 32'(md[k]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in        = '0;
    in_valid  = 1'b0;
    sel       = '0;
    auto      = 1'b0;
    out_ready = '0;

    // Reset then idle; in_ready is 1 for every sel while held in reset.
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'h00);
    chk("rst_ptr", 32'(ptr), 32'h0);
    chk("rst_out", 32'(out == '0), 32'h1);
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      @(negedge clk);
      chk($sformatf("rst_in_ready_sel%0d", s), 32'(in_ready), 32'h1);
      step();
    end

    // Explicit routing.
    reset = 1'b0;
    in = 16'h1111; sel = 3'd3; in_valid = 1'b1;
    step();
    in = 16'h2222; sel = 3'd6;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("route_valid", 32'(out_valid), 32'h48);
    chk("route_ch3", 32'(out[3*16 +: 16]), 32'h1111);
    chk("route_ch6", 32'(out[6*16 +: 16]), 32'h2222);
    chk("route_ptr", 32'(ptr), 32'h0);
    step();

    // Backpressure on a full channel, then release.
    in = 16'hBEEF; sel = 3'd3; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_ch3_hold", 32'(out[3*16 +: 16]), 32'h1111);
      step();
    end
    out_ready[3] = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    out_ready = '0;
    @(negedge clk);
    chk("bp_ch3_new", 32'(out[3*16 +: 16]), 32'hBEEF);
    chk("bp_ch3_valid", 32'(out_valid[3]), 32'h1);
    step();

    // Auto mode with the pointer wrapping; every channel draining freely.
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 8'hFF;
    auto = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in = 16'(i);
      in_valid = 1'b1;
      step();
      @(negedge clk);
      chk($sformatf("wrap_word%0d", i), 32'(out[(i%8)*16 +: 16]), 32'(i));
      chk($sformatf("wrap_valid%0d", i), 32'(out_valid[i%8]), 32'h1);
      chk($sformatf("wrap_ready%0d", i), 32'(in_ready), 32'h1);
    end
    in_valid = 1'b0;
    chk("wrap_ptr", 32'(ptr), 32'h2);
    step();

    // Fill every channel, then reset while a word is offered.
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = '0;
    for (int i = 0; i < 8; i++) begin
      in = 16'($urandom);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("fill_valid", 32'(out_valid), 32'hFF);
    chk("fill_ptr", 32'(ptr), 32'h0);
    step();
    in = 16'hA5A5; in_valid = 1'b1; reset = 1'b1;
    step();
    in_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 32'(out_valid), 32'h00);
    chk("mrst_ptr", 32'(ptr), 32'h0);
    chk("mrst_out", 32'(out == '0), 32'h1);
    step();

    // Randomized traffic, checked each cycle by the model compare.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      in        = 16'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = 3'($urandom);
      auto      = ($urandom_range(0, 1) == 1);
      out_ready = 8'($urandom) & 8'($urandom);
      step();
    end
    reset = 1'b0;
    in_valid = 1'b0;
    step();
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
